// File: rtl/truth_table_sweeper.sv
// Sequenced exhaustive checker for a combinational function of N_IN inputs.
// Steps x through every vector, samples z after a settle time, tallies errors.
module truth_table_sweeper #(
    parameter int                     N_IN        = 3,
    parameter logic [(1<<N_IN)-1:0]   TRUTH_TABLE = 8'b01100001,
    parameter int                     SETTLE      = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   z,
    output logic [N_IN-1:0]        x,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   err_mask,
    output logic [N_IN:0]          err_count
);

    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] X_LAST   = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [NV-1:0]     mask_q, mask_d;
    logic [N_IN:0]     errs_q, errs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mism;

    assign mism = (z != TRUTH_TABLE[x_q]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            errs_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            errs_q  <= errs_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        errs_d  = errs_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    mask_d  = '0;
                    errs_d  = '0;
                    pass_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    x_d     = '0;
                    pass_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                // abort outranks the compare on the same edge
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    x_d     = '0;
                    pass_d  = 1'b0;
                end else begin
                    if (mism) begin
                        mask_d[x_q] = 1'b1;
                        errs_d      = errs_q + 1'b1;
                    end
                    if (x_q == X_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        x_d     = '0;
                        pass_d  = (errs_q == '0) && !mism;
                    end else begin
                        state_d = S_SETTLE;
                        x_d     = x_q + 1'b1;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign x         = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = mask_q;
    assign err_count = errs_q;

endmodule
